// File: rtl/rgb2raw.sv
// rgb2raw: re-mosaics a 24-bit RGB pixel stream into a 16-bit Bayer RAW stream,
// two pixels per word. Even lines pack G/B pairs, odd lines pack R/G pairs.
// Optional build macro RGB2RAW_INVERT_RG_EN: complement R and G bytes before
// packing (B is never inverted); undefined packs bytes unmodified.
module rgb2raw #(
  parameter int unsigned LINE_LENGTH = 640,
  parameter int unsigned RGB_WIDTH   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RGB_WIDTH-1:0] rgb_in,
  input  logic                 rgb_valid_in,
  input  logic                 frame_start,
  output logic                 rgb_ready,
  output logic [15:0]          data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 line_end,
  output logic                 sync_err
);

  localparam int unsigned WCW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam logic [WCW-1:0] WC_LAST = WCW'(LINE_LENGTH - 1);

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_e;

  phase_e         phase_q, phase_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic           line_odd_q, line_odd_d;
  logic [7:0]     pending_q, pending_d;
  logic [15:0]    data_q, data_d;
  logic           valid_q, valid_d;
  logic           line_end_q, line_end_d;
  logic           sync_err_q, sync_err_d;

  logic           accept;
  phase_e         cur_phase;
  logic [WCW-1:0] cur_wc;
  logic           cur_odd;
  logic [7:0]     r_byte, g_byte, b_byte;

  // Channel bytes as they will be packed into the RAW word
  always_comb begin
`ifdef RGB2RAW_INVERT_RG_EN
    r_byte = ~rgb_in[23:16];
    g_byte = ~rgb_in[15:8];
`else
    r_byte = rgb_in[23:16];
    g_byte = rgb_in[15:8];
`endif
    b_byte = rgb_in[7:0];
  end

  assign rgb_ready  = !rst & (!valid_q | data_ready);
  assign accept     = rgb_valid_in & rgb_ready;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign line_end   = line_end_q;
  assign sync_err   = sync_err_q;

  // Next-state: frame_start realigns position before the pixel is processed
  always_comb begin
    phase_d    = phase_q;
    word_cnt_d = word_cnt_q;
    line_odd_d = line_odd_q;
    pending_d  = pending_q;
    data_d     = data_q;
    valid_d    = valid_q;
    line_end_d = line_end_q;
    sync_err_d = sync_err_q;
    cur_phase  = phase_q;
    cur_wc     = word_cnt_q;
    cur_odd    = line_odd_q;

    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      if (frame_start) begin
        if (phase_q != PH_FIRST || word_cnt_q != '0) begin
          sync_err_d = 1'b1;
        end
        cur_phase = PH_FIRST;
        cur_wc    = '0;
        cur_odd   = 1'b0;
      end

      if (cur_phase == PH_FIRST) begin
        pending_d  = cur_odd ? r_byte : g_byte;
        phase_d    = PH_SECOND;
        word_cnt_d = cur_wc;
        line_odd_d = cur_odd;
      end else begin
        // A load in the same cycle as a pop keeps valid high: no bubble
        data_d     = {pending_q, (cur_odd ? g_byte : b_byte)};
        valid_d    = 1'b1;
        line_end_d = (cur_wc == WC_LAST);
        phase_d    = PH_FIRST;
        if (cur_wc == WC_LAST) begin
          word_cnt_d = '0;
          line_odd_d = ~cur_odd;
        end else begin
          word_cnt_d = cur_wc + WCW'(1);
          line_odd_d = cur_odd;
        end
      end
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= PH_FIRST;
      word_cnt_q <= '0;
      line_odd_q <= 1'b0;
      pending_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      line_end_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      word_cnt_q <= word_cnt_d;
      line_odd_q <= line_odd_d;
      pending_q  <= pending_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      line_end_q <= line_end_d;
      sync_err_q <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_rgb2raw.sv
// Bench for rgb2raw: random pixel stream against a pixel-index reference model,
// scoreboard queue of expected RAW words checked by an independent monitor.
module tb_rgb2raw;

  localparam int unsigned LL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] rgb_in;
  logic        rgb_valid_in;
  logic        frame_start;
  logic        rgb_ready;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        line_end;
  logic        sync_err;

  always #5 clk = ~clk;

  rgb2raw #(.LINE_LENGTH(LL), .RGB_WIDTH(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .rgb_in       (rgb_in),
    .rgb_valid_in (rgb_valid_in),
    .frame_start  (frame_start),
    .rgb_ready    (rgb_ready),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .line_end     (line_end),
    .sync_err     (sync_err)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        le;
  } exp_t;

  exp_t        expq[$];
  int          checks   = 0;
  int          failures = 0;

  // Reference model: pixel position within a line and line parity
  int          pos      = 0;
  bit          line_par = 1'b0;
  logic [23:0] held_pix = '0;
  bit          exp_sync = 1'b0;

  int          stall_cnt = 0;
  int          rdy_mode  = 0;

  bit          hold_chk = 1'b0;
  logic [15:0] held_data;
  logic        held_le;
  exp_t        mon_e;

  function automatic logic [7:0] rb(input logic [23:0] p);
`ifdef RGB2RAW_INVERT_RG_EN
    return ~p[23:16];
`else
    return p[23:16];
`endif
  endfunction

  function automatic logic [7:0] gb(input logic [23:0] p);
`ifdef RGB2RAW_INVERT_RG_EN
    return ~p[15:8];
`else
    return p[15:8];
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic model_accept(input logic [23:0] pix, input bit fs);
    exp_t e;
    if (fs) begin
      if (pos != 0) exp_sync = 1'b1;
      pos      = 0;
      line_par = 1'b0;
    end
    if (pos % 2 == 0) begin
      held_pix = pix;
    end else begin
      e.d  = line_par ? {rb(held_pix), gb(pix)} : {gb(held_pix), pix[7:0]};
      e.le = (pos == 2 * LL - 1);
      expq.push_back(e);
    end
    pos++;
    if (pos == 2 * LL) begin
      pos      = 0;
      line_par = ~line_par;
    end
  endtask

  task automatic send_pixel(input logic [23:0] pix, input bit fs, input int gap);
    int waited;
    bit acc;
    waited = 0;
    repeat (gap) begin
      @(negedge clk);
      rgb_valid_in = 1'b0;
      frame_start  = 1'($urandom_range(0, 1));
      rgb_in       = 24'($urandom);
    end
    while (1) begin
      @(negedge clk);
      rgb_valid_in = 1'b1;
      rgb_in       = pix;
      frame_start  = fs;
      #1;
      acc = rgb_ready;
      @(posedge clk);
      if (acc) begin
        model_accept(pix, fs);
        break;
      end
      waited++;
      if (waited > 100) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=stalled required=accepted");
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rgb_valid_in = 1'b0;
      frame_start  = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      rgb_valid_in = 1'b0;
      frame_start  = 1'b0;
      n++;
    end
    idle(1);
    #3;
    chk("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  // Downstream ready: forced stalls, then either always-ready or random
  always @(negedge clk) begin
    if (stall_cnt > 0) begin
      data_ready = 1'b0;
      stall_cnt--;
    end else if (rdy_mode == 1) begin
      data_ready = ($urandom_range(0, 3) != 0);
    end else begin
      data_ready = 1'b1;
    end
  end

  // Monitor: sampled mid-cycle, ahead of the edge that completes a handshake
  always @(negedge clk) begin
    #2;
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_valid", 32'(data_valid), 32'd1);
        chk("hold_data", 32'(data_out), 32'(held_data));
        chk("hold_line_end", 32'(line_end), 32'(held_le));
      end
      hold_chk = 1'b0;
      chk("sync_err", 32'(sync_err), 32'(exp_sync));
      if (data_valid && !data_ready) begin
        chk("rgb_ready_bp", 32'(rgb_ready), 32'd0);
        hold_chk  = 1'b1;
        held_data = data_out;
        held_le   = line_end;
      end
      if (data_valid && data_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
        end else begin
          mon_e = expq.pop_front();
          chk("word_data", 32'(data_out), 32'(mon_e.d));
          chk("word_line_end", 32'(line_end), 32'(mon_e.le));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    rgb_valid_in = 1'b0;
    frame_start  = 1'b0;
    rgb_in       = '0;
    rdy_mode     = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_line_end", 32'(line_end), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_rgb_ready", 32'(rgb_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First word after reset, then valid must last exactly one cycle
    send_pixel(24'h112233, 1'b1, 0);
    send_pixel(24'h445566, 1'b0, 0);
    @(negedge clk);
    rgb_valid_in = 1'b0;
    #3;
    chk("latency_valid", 32'(data_valid), 32'd1);
    @(negedge clk);
    #3;
    chk("valid_one_cycle", 32'(data_valid), 32'd0);
    drain();

    // Finish the even line, then the first odd-line pair
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) send_pixel(24'($urandom), 1'b0, $urandom_range(0, 2));
    send_pixel(24'hA0B0C0, 1'b0, 0);
    send_pixel(24'hD0E0F0, 1'b0, 0);
    for (int i = 0; i < 6; i++) send_pixel(24'($urandom), 1'b0, $urandom_range(0, 2));
    drain();

    // Five cycles of back-pressure with a word pending
    rdy_mode = 0;
    send_pixel(24'h0102F3, 1'b0, 0);
    send_pixel(24'h0405F6, 1'b0, 0);
    stall_cnt = 5;
    send_pixel(24'h0708F9, 1'b0, 0);
    send_pixel(24'h0A0BFC, 1'b0, 0);
    drain();

    // frame_start on the third pixel of a line
    for (int i = 0; i < 4; i++) send_pixel(24'($urandom), 1'b0, 0);
    send_pixel(24'h102030, 1'b1, 0);
    send_pixel(24'h405060, 1'b0, 0);
    send_pixel(24'h708090, 1'b1, 0);
    send_pixel(24'hA1B2C3, 1'b0, 0);
    drain();
    idle(3);

    // Reset mid-line with a word and a pending pixel in flight
    send_pixel(24'h111111, 1'b0, 0);
    send_pixel(24'h222222, 1'b0, 0);
    send_pixel(24'h333333, 1'b0, 0);
    @(negedge clk);
    rst          = 1'b1;
    rgb_valid_in = 1'b0;
    frame_start  = 1'b0;
    #1;
    chk("mid_rst_data_out", 32'(data_out), 32'd0);
    chk("mid_rst_data_valid", 32'(data_valid), 32'd0);
    chk("mid_rst_line_end", 32'(line_end), 32'd0);
    chk("mid_rst_sync_err", 32'(sync_err), 32'd0);
    chk("mid_rst_rgb_ready", 32'(rgb_ready), 32'd0);
    expq.delete();
    pos      = 0;
    line_par = 1'b0;
    exp_sync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_pixel(24'h112233, 1'b0, 0);
    send_pixel(24'h445566, 1'b0, 0);
    drain();

    // Random traffic with occasional frame_start
    rdy_mode = 1;
    for (int i = 0; i < 80; i++) begin
      send_pixel(24'($urandom), ($urandom_range(0, 19) == 0), $urandom_range(0, 2));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
